// File: rtl/dtb_daq_pkg.sv
// Shared types for the DAQ merge arbiter slice.
// Stats counters are built only with DAQ_MERGE_STATS_EN.
package dtb_daq_pkg;

  localparam int DATA_W  = 16;
  localparam int ENTRY_W = DATA_W + 1;

  localparam logic SRC_ADC = 1'b0;
  localparam logic SRC_ROC = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic state_t grant_of(
    input logic src
  );
    return src ? GRANT1 : GRANT0;
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(
    input logic [DATA_W-1:0] v,
    input logic              inc
  );
    return (inc && (v != {DATA_W{1'b1}})) ?
      v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/daq_word_fifo.sv
// Per-source {last,data} word FIFO with synchronous flush.
// Full is judged on the start-of-cycle count only.
module daq_word_fifo
  import dtb_daq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        wr_en,
  input  entry_t      wr_data,
  input  logic        rd_en,
  output entry_t      rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(do_wr)
             - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/daq_merge_arbiter.sv
// Packet-aware round-robin merge of ADC and ROC word streams.
// Optional drop counters: define DAQ_MERGE_STATS_EN.
module daq_merge_arbiter
  import dtb_daq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        clr_flags,
  input  logic        s0_write,
  input  logic [15:0] s0_data,
  input  logic        s0_last,
  input  logic        s1_write,
  input  logic [15:0] s1_data,
  input  logic        s1_last,
  input  logic        daq_ready,
  output logic        daq_write,
  output logic [15:0] daq_writedata,
  output logic        daq_src,
  output logic [1:0]  ovf,
  output logic [1:0]  tmo,
`ifdef DAQ_MERGE_STATS_EN
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1,
`endif
  output logic        busy
);

  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT - 1);

  entry_t      wr0, wr1;
  entry_t      rd0, rd1;
  entry_t      pop_entry;
  logic        full0, full1;
  logic        empty0, empty1;
  logic [AW:0] cnt0, cnt1;
  logic        unused_cnt;

  state_t        state;
  logic          rr;
  logic [TW-1:0] tcnt;
  logic          cand;
  logic          pop;
  logic          pop_src;
  logic [1:0]    drop;
  logic [1:0]    tmo_set;

  assign wr0 = '{last: s0_last, data: s0_data};
  assign wr1 = '{last: s1_last, data: s1_data};

  assign drop = {run & s1_write & full1,
                 run & s0_write & full0};

  assign unused_cnt = ^{cnt0, cnt1};

  daq_word_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo0 (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (~run),
    .wr_en  (run & s0_write),
    .wr_data(wr0),
    .rd_en  (pop & (pop_src == SRC_ADC)),
    .rd_data(rd0),
    .full   (full0),
    .empty  (empty0),
    .count  (cnt0)
  );

  daq_word_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo1 (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (~run),
    .wr_en  (run & s1_write),
    .wr_data(wr1),
    .rd_en  (pop & (pop_src == SRC_ROC)),
    .rd_data(rd1),
    .full   (full1),
    .empty  (empty1),
    .count  (cnt1)
  );

  // rr is preferred in IDLE; fall back to the other source
  always_comb begin
    cand    = (rr ? !empty1 : !empty0) ? rr : ~rr;
    pop     = 1'b0;
    pop_src = cand;
    tmo_set = 2'b00;
    case (state)
      IDLE: begin
        pop = daq_ready & ~(empty0 & empty1);
      end
      GRANT0: begin
        pop_src    = SRC_ADC;
        pop        = daq_ready & ~empty0;
        tmo_set[0] = daq_ready & empty0 &
                     (tcnt == TMO_LAST);
      end
      GRANT1: begin
        pop_src    = SRC_ROC;
        pop        = daq_ready & ~empty1;
        tmo_set[1] = daq_ready & empty1 &
                     (tcnt == TMO_LAST);
      end
      default: ;
    endcase
    if (!run) begin
      pop     = 1'b0;
      tmo_set = 2'b00;
    end
    pop_entry = pop_src ? rd1 : rd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr            <= SRC_ADC;
      tcnt          <= '0;
      tmo           <= 2'b00;
      daq_write     <= 1'b0;
      daq_writedata <= '0;
      daq_src       <= 1'b0;
    end else begin
      daq_write <= pop;
      if (pop) begin
        daq_writedata <= pop_entry.data;
        daq_src       <= pop_src;
      end
      tmo <= (clr_flags ? 2'b00 : tmo) | tmo_set;
      if (!run) begin
        state <= IDLE;
        tcnt  <= '0;
      end else if (pop && pop_entry.last) begin
        state <= IDLE;
        rr    <= ~pop_src;
        tcnt  <= '0;
      end else if (pop) begin
        state <= grant_of(pop_src);
        tcnt  <= '0;
      end else if (|tmo_set) begin
        state <= IDLE;
        rr    <= ~pop_src;
        tcnt  <= '0;
      end else if (state != IDLE && daq_ready) begin
        tcnt  <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf <= 2'b00;
    else
      ovf <= (clr_flags ? 2'b00 : ovf) | drop;
  end

`ifdef DAQ_MERGE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt0 <= '0;
      drop_cnt1 <= '0;
    end else begin
      drop_cnt0 <= sat_inc(
        clr_flags ? 16'h0 : drop_cnt0, drop[0]);
      drop_cnt1 <= sat_inc(
        clr_flags ? 16'h0 : drop_cnt1, drop[1]);
    end
  end
`else
  // drops are visible only through the sticky ovf bits
`endif

  assign busy = (state != IDLE) | ~empty0 | ~empty1;

endmodule

// File: tb/tb_daq_merge_arbiter.sv
// Directed bench for daq_merge_arbiter.
// Build with DAQ_MERGE_STATS_EN to also check drop counters.
module tb_daq_merge_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        clr_flags;
  logic        s0_write;
  logic [15:0] s0_data;
  logic        s0_last;
  logic        s1_write;
  logic [15:0] s1_data;
  logic        s1_last;
  logic        daq_ready;
  logic        daq_write;
  logic [15:0] daq_writedata;
  logic        daq_src;
  logic [1:0]  ovf;
  logic [1:0]  tmo;
  logic        busy;
`ifdef DAQ_MERGE_STATS_EN
  logic [15:0] drop_cnt0;
  logic [15:0] drop_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  daq_merge_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .clr_flags    (clr_flags),
    .s0_write     (s0_write),
    .s0_data      (s0_data),
    .s0_last      (s0_last),
    .s1_write     (s1_write),
    .s1_data      (s1_data),
    .s1_last      (s1_last),
    .daq_ready    (daq_ready),
    .daq_write    (daq_write),
    .daq_writedata(daq_writedata),
    .daq_src      (daq_src),
    .ovf          (ovf),
    .tmo          (tmo),
`ifdef DAQ_MERGE_STATS_EN
    .drop_cnt0    (drop_cnt0),
    .drop_cnt1    (drop_cnt1),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n && daq_write)
      got_q.push_back({daq_src, daq_writedata});

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        check($sformatf("%s word%0d", tag, i),
              got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_flags = 1'b0;
    s0_write  = 1'b0;
    s0_data   = '0;
    s0_last   = 1'b0;
    s1_write  = 1'b0;
    s1_data   = '0;
    s1_last   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    run       = 1'b1;
    daq_ready = 1'b1;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic put0(input logic [15:0] d, input logic l);
    s0_write = 1'b1;
    s0_data  = d;
    s0_last  = l;
  endtask

  task automatic put1(input logic [15:0] d, input logic l);
    s1_write = 1'b1;
    s1_data  = d;
    s1_last  = l;
  endtask

  task automatic burst2();
    put0(16'h00A0, 1'b0);
    put1(16'h00B0, 1'b0);
    tick();
    put0(16'h00A1, 1'b1);
    put1(16'h00B1, 1'b1);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    run       = 1'b1;
    daq_ready = 1'b1;
    reset_n   = 1'b0;
    #3;
    check("rst daq_write", daq_write, 0);
    check("rst writedata", daq_writedata, 0);
    check("rst daq_src", daq_src, 0);
    check("rst ovf", ovf, 0);
    check("rst tmo", tmo, 0);
    check("rst busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single 3-word packet, latency and order
    put0(16'h1001, 1'b0);
    tick();
    check("t1 lat0", daq_write, 0);
    put0(16'h1002, 1'b0);
    tick();
    check("t1 w0 strobe", daq_write, 1);
    check("t1 w0 data", daq_writedata, 16'h1001);
    check("t1 w0 src", daq_src, 0);
    put0(16'h1003, 1'b1);
    tick();
    check("t1 w1 data", daq_writedata, 16'h1002);
    idle_inputs();
    tick();
    check("t1 w2 strobe", daq_write, 1);
    check("t1 w2 data", daq_writedata, 16'h1003);
    tick();
    check("t1 done strobe", daq_write, 0);
    check("t1 hold data", daq_writedata, 16'h1003);
    check("t1 busy", busy, 0);

    // 2: simultaneous packets, no interleave, rr alternation
    do_reset();
    burst2();
    repeat (6) tick();
    exp_q = '{{1'b0, 16'h00A0}, {1'b0, 16'h00A1},
              {1'b1, 16'h00B0}, {1'b1, 16'h00B1}};
    check_q("t2 burst1");
    put0(16'h00C0, 1'b1);
    tick();
    idle_inputs();
    repeat (3) tick();
    burst2();
    repeat (6) tick();
    exp_q = '{{1'b0, 16'h00C0},
              {1'b1, 16'h00B0}, {1'b1, 16'h00B1},
              {1'b0, 16'h00A0}, {1'b0, 16'h00A1}};
    check_q("t2 burst2");
    check("t2 ovf", ovf, 0);

    // 3: packet timeout with a pending ROC packet
    do_reset();
    put0(16'h0001, 1'b0);
    tick();
    idle_inputs();
    put1(16'h0B01, 1'b0);
    tick();
    put1(16'h0B02, 1'b1);
    tick();
    idle_inputs();
    repeat (253) tick();
    check("t3 tmo early", tmo, 0);
    check("t3 held", got_q.size(), 1);
    tick();
    check("t3 tmo set", tmo, 2'b01);
    repeat (4) tick();
    exp_q = '{{1'b0, 16'h0001},
              {1'b1, 16'h0B01}, {1'b1, 16'h0B02}};
    check_q("t3 order");
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t3 tmo clr", tmo, 0);

    // 4: overflow of the ROC FIFO while stalled
    do_reset();
    daq_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      put1(16'h4000 + 16'(i), i == 15);
      tick();
    end
    idle_inputs();
    check("t4 ovf", ovf, 2'b10);
    check("t4 stalled", got_q.size(), 0);
`ifdef DAQ_MERGE_STATS_EN
    check("t4 drop_cnt1", drop_cnt1, 4);
    check("t4 drop_cnt0", drop_cnt0, 0);
`endif
    daq_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 16; i++)
      exp_q.push_back({1'b1, 16'h4000 + 16'(i)});
    check_q("t4 words");
    check("t4 busy", busy, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t4 ovf clr", ovf, 0);
`ifdef DAQ_MERGE_STATS_EN
    check("t4 cnt clr", drop_cnt1, 0);
`endif

    // 5: run dropped mid-packet flushes buffered words
    do_reset();
    daq_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      put0(16'h5000 + 16'(i), 1'b0);
      tick();
    end
    idle_inputs();
    daq_ready = 1'b1;
    tick();
    tick();
    run = 1'b0;
    put0(16'h5EEE, 1'b1);
    tick();
    idle_inputs();
    check("t5 no write", daq_write, 0);
    check("t5 busy", busy, 0);
    repeat (3) tick();
    check("t5 ovf kept 0", ovf, 0);
    exp_q = '{{1'b0, 16'h5000}, {1'b0, 16'h5001}};
    check_q("t5 before");
    run = 1'b1;
    put0(16'h5100, 1'b0);
    tick();
    put0(16'h5101, 1'b1);
    tick();
    idle_inputs();
    repeat (4) tick();
    exp_q = '{{1'b0, 16'h5100}, {1'b0, 16'h5101}};
    check_q("t5 after");
    check("t5 busy end", busy, 0);

    // 6: async reset mid-packet
    do_reset();
    daq_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      put0(16'h6000 + 16'(i), i == 2);
      tick();
    end
    idle_inputs();
    check("t6 ovf pre", ovf, 2'b01);
    daq_ready = 1'b1;
    tick();
    tick();
    check("t6 pre strobe", daq_write, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async write", daq_write, 0);
    check("t6 async data", daq_writedata, 0);
    check("t6 async ovf", ovf, 0);
    check("t6 async busy", busy, 0);
    tick();
    reset_n = 1'b1;
    got_q.delete();
    repeat (4) tick();
    check("t6 no words", got_q.size(), 0);
    check("t6 busy", busy, 0);
    check("t6 tmo", tmo, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/daq_merge_arbiter.md
Name: daq_merge_arbiter

Overview:
Packet-aware arbiter that merges two 16-bit DAQ word streams into a single DAQ output channel: analog ADC readout (source 0) and ROC deserializer (source 1).
- Each source is buffered in its own small FIFO.
- Sources are granted round-robin, and a granted source holds the output until its packet's last word has gone out, so packets never interleave.
- Sits between the readout front ends and the daq0 write port; replaces direct OR-merging of the write strobes, so collisions can no longer corrupt words.

Parameters:
DEPTH, 16, words per source FIFO (power of 2, >= 4)
AW, 4, log2(DEPTH)
TIMEOUT, 255, max idle cycles inside a granted packet before forced release
TW, 8, timeout counter width (2^TW > TIMEOUT)

Ports:
clk  in  1  system/DAQ clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
run  in  1  DAQ running; low = flush and ignore inputs
clr_flags  in  1  synchronous clear of ovf/tmo sticky flags
s0_write  in  1  source 0 word strobe
s0_data  in  16  source 0 word
s0_last  in  1  source 0 last word of packet (qualified by s0_write)
s1_write  in  1  source 1 word strobe
s1_data  in  16  source 1 word
s1_last  in  1  source 1 last word of packet
daq_ready  in  1  downstream can accept a word this cycle
daq_write  out  1  output word strobe, one cycle per word
daq_writedata  out  16  output word
daq_src  out  1  source index of current output word
ovf  out  2  sticky per-source overflow (word dropped)
tmo  out  2  sticky per-source packet timeout
busy  out  1  high when arbiter is not IDLE or any FIFO is non-empty

Behaviour:
- Reset (async, reset_n=0):
  - daq_write=0, daq_writedata=0, daq_src=0, ovf=0, tmo=0, busy=0.
  - FIFOs empty, state IDLE, rr pointer=0, timeout counter=0.
- FIFO entries are {last,data}, 17 bits.
  - A write is accepted when run=1 and count<DEPTH, using the count at the start of the cycle; a simultaneous pop does not make room in that cycle.
  - A rejected write while run=1 sets ovf[i]. The word is dropped and no packet repair is done.
- run=0: both FIFOs flushed synchronously, state goes to IDLE, daq_write=0, writes ignored. Flags are kept.
- clr_flags=1 clears ovf/tmo. If a new flag event occurs in the same cycle, the set wins.
- State machine, states IDLE, GRANT0, GRANT1:
  - IDLE: the candidate is source rr if non-empty, else the other source.
    - If there is a candidate and daq_ready=1: pop one word and output it.
    - If that word has last=1: stay in IDLE and set rr to the other source.
    - Otherwise: go to GRANTi.
  - GRANTi: each cycle with daq_ready=1 and FIFO i non-empty, pop and output one word and reset the timeout counter.
    - On a popped last=1: go to IDLE, rr = other source.
    - With FIFO i empty: the timeout counter increments. When it reaches TIMEOUT: set tmo[i], go to IDLE, rr = other source.
    - daq_ready=0 stalls without counting.
- Output register: daq_write/daq_writedata/daq_src are loaded on the pop edge and valid for exactly one cycle. daq_write=0 on non-pop cycles; daq_writedata holds its last value.
- Latency: a word written at edge t with both FIFOs previously empty, IDLE, and daq_ready=1 gives daq_write=1 in cycle t+2 (pipeline: FIFO write, pop, output register).
- Throughput: 1 word/cycle sustained within a packet. At least one word from the other source between packets when both are pending.
- daq_ready is sampled only in the pop decision. Once daq_write is asserted, the word is not retracted.

Optional Feature:
DAQ_MERGE_STATS_EN:
- Defined: adds outputs drop_cnt0 and drop_cnt1 (16 bits each). These are saturating counts of dropped words per source, cleared by clr_flags and by reset, and kept across run=0.
- Undefined: the ports and counters are absent. ovf sticky bits only.

Decomposition:
- Package dtb_daq_pkg:
  - state enum (IDLE, GRANT0, GRANT1)
  - source index constants SRC_ADC=0, SRC_ROC=1
  - FIFO entry width 17
- Sub-module daq_word_fifo: synchronous FIFO with flush, full/empty/count, depth DEPTH. Instantiated twice.

Test Plan:
1. Source 0 writes a 3-word packet 0x1001, 0x1002, 0x1003 (last on 3rd), daq_ready=1 → daq_write in cycles t+2..t+4, data in order, daq_src=0.
2. Both sources write 2-word packets in the same cycle (s0: 0xA0,0xA1; s1: 0xB0,0xB1), rr=0 → output order A0,A1,B0,B1, no interleave. A second identical burst then gives B-packet first.
3. s0 sends 0x0001 without last, then stays silent, TIMEOUT=255 → tmo[0]=1 after 255 stall cycles. A pending s1 packet follows immediately.
4. daq_ready=0 while s1 writes 20 words, DEPTH=16 → ovf[1]=1, 16 words delivered after daq_ready=1, 4 dropped. With DAQ_MERGE_STATS_EN, drop_cnt1=4.
5. Assert run=0 mid-packet with 5 words buffered → no further daq_write, busy=0 next cycle. A new packet after run=1 is delivered cleanly from IDLE.
6. reset_n low mid-packet (async, between edges) → all outputs 0 immediately. Flags 0, FIFOs empty after release.
